turn_arbiter_m: RTL

//  Game sequencer between player_m, the AI and the board. Owns `turn`, grants the shared

---
 rtl/turn_arbiter_m_pkg.sv | 42 ++++
 rtl/turn_arbiter_m_if.sv | 27 ++
 rtl/turn_arbiter_m_watchdog.sv | 38 +++
 rtl/turn_arbiter_m.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/turn_arbiter_m_pkg.sv
// Shared types and constants for the turn arbiter.
// Turn codes, winner codes, FSM states and cell legality helper.
package turn_arbiter_m_pkg;

    localparam logic TURN_PLAYER = 1'b0;
    localparam logic TURN_AI     = 1'b1;
    localparam int   NUM_CELLS   = 9;

    typedef enum logic [1:0] {
        WIN_NONE   = 2'd0,
        WIN_PLAYER = 2'd1,
        WIN_AI     = 2'd2,
        WIN_TIE    = 2'd3
    } win_t;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_WAIT_MOVE,
        ST_COMMIT,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } arb_state_t;

    // Out-of-range indices (9..15) are never free.
    function automatic logic cell_free(
        input logic [3:0] loc,
        input logic [8:0] occ
    );
        logic free;
        free = 1'b0;
        if (loc < 4'(NUM_CELLS)) begin
            free = ~occ[loc];
        end
        return free;
    endfunction

    function automatic win_t side_code(input logic side);
        return side ? WIN_AI : WIN_PLAYER;
    endfunction

endpackage

// File: rtl/turn_arbiter_m_if.sv
// Board-side move bus between the turn arbiter and the board.
// master: arbiter drives loc/submit/reset; slave: board reports occupancy/win.
interface turn_arbiter_m_if;

    logic [3:0] board_loc;
    logic       board_submit;
    logic       board_reset;
    logic [8:0] board_occupied;
    logic       board_win;

    modport master (
        output board_loc,
        output board_submit,
        output board_reset,
        input  board_occupied,
        input  board_win
    );

    modport slave (
        input  board_loc,
        input  board_submit,
        input  board_reset,
        output board_occupied,
        output board_win
    );

endinterface

// File: rtl/turn_arbiter_m_watchdog.sv
// Per-turn idle watchdog: counts enabled cycles, flags the last one.
// Ports: clk, rst_n, clr (zero count), en (count this cycle), expired.
module turn_watchdog_m #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // expired marks the TIMEOUT_CYCLES-th enabled cycle.
    assign expired = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/turn_arbiter_m.sv
// Game sequencer: grants the move bus to the side on turn, validates and
// commits moves, detects win/tie/forfeit. Board signals via bus (master).
module turn_arbiter_m
    import turn_arbiter_m_pkg::*;
#(
    parameter bit FIRST_TURN     = 1'b0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_game,
    input  logic [3:0]         player_loc,
    input  logic               player_submit,
    input  logic [3:0]         ai_loc,
    input  logic               ai_submit,
    turn_arbiter_m_if.master   bus,
    output logic               turn,
    output logic [3:0]         move_count,
    output logic               illegal_move,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               timeout
);

    arb_state_t state_q, state_d;
    logic       turn_q, turn_d;
    logic [3:0] loc_q, loc_d;
    logic       submit_q, submit_d;
    logic       breset_q, breset_d;
    logic [3:0] count_q, count_d;
    logic       illegal_q, illegal_d;
    logic       over_q, over_d;
    win_t       winner_q, winner_d;
    logic       tmo_q, tmo_d;
    logic       psub_q, asub_q;

    logic       wd_clr;
    logic       wd_en;
    logic       wd_expired;
    logic       own_rise;
    logic [3:0] own_loc;

    // Edge registers track both sides every cycle so a level held
    // across a turn change never looks like a fresh submit.
    assign own_rise = turn_q ? (ai_submit && !asub_q)
                             : (player_submit && !psub_q);
    assign own_loc  = turn_q ? ai_loc : player_loc;
    assign wd_en    = (state_q == ST_WAIT_MOVE);

    turn_watchdog_m #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        turn_d    = turn_q;
        loc_d     = loc_q;
        submit_d  = 1'b0;
        breset_d  = 1'b0;
        count_d   = count_q;
        illegal_d = 1'b0;
        over_d    = over_q;
        winner_d  = winner_q;
        tmo_d     = tmo_q;
        wd_clr    = 1'b0;

        if (new_game) begin
            state_d = ST_CLEAR;
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    breset_d = 1'b1;
                    count_d  = 4'd0;
                    winner_d = WIN_NONE;
                    over_d   = 1'b0;
                    tmo_d    = 1'b0;
                    turn_d   = FIRST_TURN;
                    wd_clr   = 1'b1;
                    state_d  = ST_WAIT_MOVE;
                end
                ST_WAIT_MOVE: begin
                    // Forfeit outranks a legal move in the same cycle.
                    if (wd_expired) begin
                        tmo_d    = 1'b1;
                        winner_d = side_code(!turn_q);
                        over_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else if (own_rise) begin
                        if (cell_free(own_loc, bus.board_occupied)) begin
                            loc_d    = own_loc;
                            submit_d = 1'b1;
                            state_d  = ST_COMMIT;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (count_q < 4'(NUM_CELLS)) begin
                        count_d = count_q + 4'd1;
                    end
                    state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (bus.board_win) begin
                        winner_d = side_code(turn_q);
                        over_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else if (count_q == 4'(NUM_CELLS)) begin
                        winner_d = WIN_TIE;
                        over_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        turn_d  = !turn_q;
                        wd_clr  = 1'b1;
                        state_d = ST_WAIT_MOVE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            turn_q    <= FIRST_TURN;
            loc_q     <= 4'd0;
            submit_q  <= 1'b0;
            breset_q  <= 1'b0;
            count_q   <= 4'd0;
            illegal_q <= 1'b0;
            over_q    <= 1'b0;
            winner_q  <= WIN_NONE;
            tmo_q     <= 1'b0;
            psub_q    <= 1'b0;
            asub_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            loc_q     <= loc_d;
            submit_q  <= submit_d;
            breset_q  <= breset_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            over_q    <= over_d;
            winner_q  <= winner_d;
            tmo_q     <= tmo_d;
            psub_q    <= player_submit;
            asub_q    <= ai_submit;
        end
    end

    assign bus.board_loc    = loc_q;
    assign bus.board_submit = submit_q;
    assign bus.board_reset  = breset_q;
    assign turn             = turn_q;
    assign move_count       = count_q;
    assign illegal_move     = illegal_q;
    assign game_over        = over_q;
    assign winner           = winner_q;
    assign timeout          = tmo_q;

endmodule
